// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - shared single-port memory responder for an instruction port and a data port; define MEM_RESP_ERR_EN to add o_data_err
module mem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_instr_addr,
  output logic [XLEN-1:0] o_instr_data,
  input  logic            i_instr_req,
  output logic            o_instr_ack,
  input  logic [XLEN-1:0] i_data_addr,
  output logic [XLEN-1:0] o_data_rd_data,
  input  logic [XLEN-1:0] i_data_wr_data,
  input  logic [1:0]      i_data_size,
  input  logic            i_data_we,
  input  logic            i_data_req,
  output logic            o_data_ack
`ifdef MEM_RESP_ERR_EN
  ,
  output logic            o_data_err
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic            r_is_data;
  logic            r_last_data;
  logic            r_we;
  logic [1:0]      r_size;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_instr_data;
  logic [XLEN-1:0] r_data_rd;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic            w_grant;
  logic            w_grant_data;
  logic            w_sel_data;
  logic            w_sel_we;
  logic [1:0]      w_sel_size;
  logic [XLEN-1:0] w_sel_addr;
  logic [AW-1:0]   w_idx;
  logic            w_bad;
  logic [4:0]      w_shift;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_rd_fmt;
  logic [XLEN-1:0] w_merged;

  // Arbitration: data first, but instruction wins a tie right after a data grant.
  assign w_grant      = (r_state == S_IDLE) && (i_instr_req || i_data_req);
  assign w_grant_data = i_data_req && (!i_instr_req || !r_last_data);

  // Access attributes: live from the winning port in IDLE, latched copy afterwards.
  always_comb begin
    w_sel_data = r_is_data;
    w_sel_we   = r_we;
    w_sel_size = r_size;
    w_sel_addr = r_addr;
    if (r_state == S_IDLE) begin
      w_sel_data = w_grant_data;
      w_sel_we   = w_grant_data && i_data_we;
      w_sel_size = w_grant_data ? i_data_size : 2'b10;
      w_sel_addr = w_grant_data ? i_data_addr : i_instr_addr;
    end
  end

  assign w_idx  = w_sel_addr[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_bad  = w_sel_data && ((w_sel_size == 2'b11) ||
                                 ((w_sel_size == 2'b01) && w_sel_addr[0]) ||
                                 ((w_sel_size == 2'b10) && (w_sel_addr[1:0] != 2'b00)));

  // Byte-lane mask and shift for sub-word reads and writes.
  always_comb begin
    w_shift = 5'd0;
    w_lane  = '1;
    case (w_sel_size)
      2'b00: begin
        w_shift = {w_sel_addr[1:0], 3'b000};
        w_lane  = XLEN'(8'hFF) << w_shift;
      end
      2'b01: begin
        w_shift = {w_sel_addr[1], 4'b0000};
        w_lane  = XLEN'(16'hFFFF) << w_shift;
      end
      2'b10:   w_lane = '1;
      default: w_lane = '0;
    endcase
  end

  assign w_rd_fmt = w_bad ? '0 : ((w_word & w_lane) >> w_shift);
  assign w_merged = (w_word & ~w_lane) | ((r_wdata << w_shift) & w_lane);

  // Next-state logic: IDLE -> WAIT (counted) -> ACK -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant) w_next = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
      S_WAIT: if (r_cnt == LAST_WAIT) w_next = S_ACK;
      S_ACK:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, wait counter, request latches and held read-data outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_data  <= 1'b0;
      r_is_data    <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_instr_data <= '0;
      r_data_rd    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_cnt       <= 4'd0;
        r_is_data   <= w_grant_data;
        r_last_data <= w_grant_data;
        r_we        <= w_sel_we;
        r_size      <= w_sel_size;
        r_addr      <= w_sel_addr;
        r_wdata     <= i_data_wr_data;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_next == S_ACK) begin
        if (w_sel_data) r_data_rd    <= w_rd_fmt;
        else            r_instr_data <= w_word;
      end
    end
  end

  // Write commits at the edge that ends ACK, unless reset lands on that edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == S_ACK) && r_is_data && r_we && !w_bad) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign o_instr_data   = r_instr_data;
  assign o_data_rd_data = r_data_rd;
  assign o_instr_ack    = (r_state == S_ACK) && !r_is_data && !i_rst;
  assign o_data_ack     = (r_state == S_ACK) && r_is_data && !i_rst;
`ifdef MEM_RESP_ERR_EN
  assign o_data_err     = o_data_ack && w_bad;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (XLEN=32, DEPTH_WORDS=1024, WAIT_CYCLES=1)
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] data_addr;
  logic [31:0] data_rd;
  logic [31:0] data_wd;
  logic [1:0]  data_size;
  logic        data_we;
  logic        data_req;
  logic        data_ack;
`ifdef MEM_RESP_ERR_EN
  logic        data_err;
`endif

  always #5 clk = ~clk;

  mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_instr_addr(instr_addr),
    .o_instr_data(instr_data),
    .i_instr_req(instr_req),
    .o_instr_ack(instr_ack),
    .i_data_addr(data_addr),
    .o_data_rd_data(data_rd),
    .i_data_wr_data(data_wd),
    .i_data_size(data_size),
    .i_data_we(data_we),
    .i_data_req(data_req),
    .o_data_ack(data_ack)
`ifdef MEM_RESP_ERR_EN
    ,
    .o_data_err(data_err)
`endif
  );

  typedef struct {
    bit          is_data;
    bit          chk;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input bit is_data, input bit chk, input logic [31:0] d, input bit err);
    exp_t e;
    e.is_data = is_data;
    e.chk     = chk;
    e.data    = d;
    e.err     = err;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per ack and checks port, data, error flag and pulse width.
  initial begin
    bit   prev_ack = 1'b0;
    bit   have;
    exp_t e;
    forever begin
      @(negedge clk);
      if (instr_ack || data_ack) begin
        check("ack_overlap", 32'(instr_ack && data_ack), 32'd0);
        check("ack_pulse", 32'(prev_ack), 32'd0);
        have = (q.size() != 0);
        check("ack_expected", 32'(have), 32'd1);
        if (have) begin
          e = q.pop_front();
          check("ack_port", 32'(data_ack), 32'(e.is_data));
          if (e.chk) check("rd_value", e.is_data ? data_rd : instr_data, e.data);
`ifdef MEM_RESP_ERR_EN
          if (e.is_data) check("data_err", 32'(data_err), 32'(e.err));
`endif
        end
      end
      prev_ack = instr_ack || data_ack;
    end
  end

  task automatic data_access(input logic [31:0] addr, input logic [1:0] size, input logic we,
                             input logic [31:0] wd, input bit chk, input logic [31:0] exp,
                             input bit err);
    int n = 0;
    bit got = 1'b0;
    push(1'b1, chk, exp, err);
    @(posedge clk); #1;
    data_addr = addr; data_size = size; data_we = we; data_wd = wd; data_req = 1'b1;
    while (!got && n < 50) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (data_ack) got = 1'b1;
    end
    check("data_ack_seen", 32'(got), 32'd1);
    check("data_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic instr_access(input logic [31:0] addr, input logic [31:0] exp);
    int n = 0;
    bit got = 1'b0;
    push(1'b0, 1'b1, exp, 1'b0);
    @(posedge clk); #1;
    instr_addr = addr; instr_req = 1'b1;
    while (!got && n < 50) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (instr_ack) got = 1'b1;
    end
    check("instr_ack_seen", 32'(got), 32'd1);
    check("instr_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    instr_req = 1'b0;
  endtask

  // Both ports request in the same cycle; each drops its req in the cycle after its ack.
  task automatic both_read(input logic [31:0] daddr, input logic [31:0] iaddr);
    int n = 0;
    bit dgot = 1'b0, igot = 1'b0, dn, in_;
    @(posedge clk); #1;
    data_addr = daddr; data_size = 2'b10; data_we = 1'b0; data_wd = 32'h0;
    instr_addr = iaddr;
    data_req = 1'b1; instr_req = 1'b1;
    while (!(dgot && igot) && n < 50) begin
      @(negedge clk);
      dn = data_ack; in_ = instr_ack;
      @(posedge clk); #1; n++;
      if (dn)  begin dgot = 1'b1; data_req  = 1'b0; end
      if (in_) begin igot = 1'b1; instr_req = 1'b0; end
    end
    check("both_done", 32'(dgot && igot), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    instr_addr = '0; instr_req = 1'b0;
    data_addr = '0; data_wd = '0; data_size = 2'b10; data_we = 1'b0; data_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_instr_ack", 32'(instr_ack), 32'd0);
    check("rst_data_ack", 32'(data_ack), 32'd0);
    check("rst_data_rd", data_rd, 32'd0);
    check("rst_instr_data", instr_data, 32'd0);

    // Word write then read back.
    data_access(32'h40, 2'b10, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    data_access(32'h40, 2'b10, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Byte and half lanes, zero-extended reads.
    data_access(32'h40, 2'b10, 1'b1, 32'h00000000, 1'b0, 32'h0, 1'b0);
    data_access(32'h41, 2'b00, 1'b1, 32'h123456A5, 1'b0, 32'h0, 1'b0);
    data_access(32'h41, 2'b00, 1'b0, 32'h0, 1'b1, 32'h000000A5, 1'b0);
    data_access(32'h40, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0000A500, 1'b0);
    data_access(32'h42, 2'b01, 1'b1, 32'h9999BEEF, 1'b0, 32'h0, 1'b0);
    data_access(32'h42, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0000BEEF, 1'b0);
    data_access(32'h43, 2'b00, 1'b0, 32'h0, 1'b1, 32'h000000BE, 1'b0);
    data_access(32'h40, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0000A500, 1'b0);
    data_access(32'h40, 2'b10, 1'b0, 32'h0, 1'b1, 32'hBEEFA500, 1'b0);

    // Misaligned and reserved-size accesses.
    data_access(32'h40, 2'b10, 1'b1, 32'h11223344, 1'b0, 32'h0, 1'b0);
    data_access(32'h43, 2'b01, 1'b1, 32'h00005566, 1'b0, 32'h0, 1'b1);
    data_access(32'h40, 2'b10, 1'b0, 32'h0, 1'b1, 32'h11223344, 1'b0);
    data_access(32'h40, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    data_access(32'h42, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    data_access(32'h41, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    data_access(32'h40, 2'b11, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    data_access(32'h40, 2'b10, 1'b0, 32'h0, 1'b1, 32'h11223344, 1'b0);

    // Address wrap on the instruction port; addr[1:0] ignored.
    data_access(32'h0004, 2'b10, 1'b1, 32'h0BADC0DE, 1'b0, 32'h0, 1'b0);
    instr_access(32'h1004, 32'h0BADC0DE);
    instr_access(32'h1007, 32'h0BADC0DE);

    // Contention after an instruction grant: data, instr, data, instr.
    push(1'b1, 1'b1, 32'h11223344, 1'b0);
    push(1'b0, 1'b1, 32'h0BADC0DE, 1'b0);
    both_read(32'h40, 32'h4);
    push(1'b1, 1'b1, 32'h11223344, 1'b0);
    push(1'b0, 1'b1, 32'h0BADC0DE, 1'b0);
    both_read(32'h40, 32'h4);

    // Contention right after a data grant: instruction goes first.
    data_access(32'h4, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0BADC0DE, 1'b0);
    push(1'b0, 1'b1, 32'h0BADC0DE, 1'b0);
    push(1'b1, 1'b1, 32'h11223344, 1'b0);
    both_read(32'h40, 32'h1004);

    // Reset during the ACK cycle of a write drops the write and the ack.
    data_access(32'h80, 2'b10, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    data_access(32'h80, 2'b10, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
    @(posedge clk); #1;
    data_addr = 32'h80; data_size = 2'b10; data_we = 1'b1; data_wd = 32'h12345678; data_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ack_no_ack", 32'(data_ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; data_req = 1'b0;
    @(negedge clk);
    check("rst2_data_rd", data_rd, 32'd0);
    check("rst2_instr_data", instr_data, 32'd0);
    data_access(32'h80, 2'b10, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);

    repeat (4) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
